// File: rtl/decode_pipe_stage.sv
// decode_pipe_stage: RV32 decode with register file, WB bypass,
// load-use detection and a valid/ready ID/EX register.
module decode_pipe_stage #(
    parameter int XLEN     = 32,
    parameter int NUM_REGS = 32,
    parameter bit ENABLE_M = 1'b0,
    parameter bit BYPASS   = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_valid,
    output logic            if_ready,
    input  logic [31:0]     instruction_in,
    input  logic [XLEN-1:0] pc_in,
    input  logic            id_flush,
    input  logic            ex_ready,
    input  logic            reg_file_wr_en,
    input  logic [4:0]      reg_file_wr_addr,
    input  logic [XLEN-1:0] reg_file_wr_data,
    output logic            id_valid,
    output logic            stall,
    output logic [XLEN-1:0] id_pc,
    output logic [XLEN-1:0] op1,
    output logic [XLEN-1:0] op2,
    output logic [XLEN-1:0] immediate,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [4:0]      rd,
    output logic [6:0]      opcode,
    output logic [6:0]      func7,
    output logic [2:0]      func3,
    output logic            alu_src,
    output logic            mem_write,
    output logic            wb_load,
    output logic            wb_reg_file,
    output logic            invalid_inst,
    output logic            is_m_op,
    output logic [2:0]      mem_load_type,
    output logic [1:0]      mem_store_type
);

    localparam int AW = $clog2(NUM_REGS);

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] op1;
        logic [XLEN-1:0] op2;
        logic [XLEN-1:0] imm;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [6:0]      opcode;
        logic [6:0]      func7;
        logic [2:0]      func3;
        logic            alu_src;
        logic            mem_write;
        logic            wb_load;
        logic            wb_reg_file;
        logic            invalid_inst;
        logic            is_m_op;
        logic [2:0]      mem_load_type;
        logic [1:0]      mem_store_type;
        logic            rs1_used;
        logic            rs2_used;
    } id_ex_t;

    // A bubble carries the fields of a canonical nop with every control low.
    function automatic id_ex_t bubble();
        id_ex_t b;
        b = '0;
        b.opcode = OP_IMM;
        b.mem_load_type = 3'b111;
        b.mem_store_type = 2'b11;
        return b;
    endfunction

    function automatic logic in_range(input logic [4:0] a);
        return {1'b0, a} < 6'(NUM_REGS);
    endfunction

    logic [XLEN-1:0] regs [NUM_REGS];
    logic            wr_ok;
    logic [6:0]      op;
    logic [6:0]      f7;
    logic [2:0]      f3;
    logic [4:0]      a1;
    logic [4:0]      a2;
    logic [4:0]      ad;
    logic            rd1_ok;
    logic            rd2_ok;
    logic [XLEN-1:0] rd1_data;
    logic [XLEN-1:0] rd2_data;
    logic [31:0]     imm32;
    logic            illegal;
    logic            m_enc;
    logic            e_bad;
    id_ex_t          dec;
    id_ex_t          q;
    logic            valid_q;
    logic            hazard;
    logic            advance;
    logic            ref1;
    logic            ref2;

    assign op = instruction_in[6:0];
    assign ad = instruction_in[11:7];
    assign f3 = instruction_in[14:12];
    assign a1 = instruction_in[19:15];
    assign a2 = instruction_in[24:20];
    assign f7 = instruction_in[31:25];

    assign wr_ok = reg_file_wr_en && reg_file_wr_addr != 5'd0
                   && in_range(reg_file_wr_addr);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_ok) begin
            regs[reg_file_wr_addr[AW-1:0]] <= reg_file_wr_data;
        end
    end

    assign rd1_ok = a1 != 5'd0 && in_range(a1);
    assign rd2_ok = a2 != 5'd0 && in_range(a2);

    assign rd1_data = !rd1_ok ? '0 :
                      (BYPASS && wr_ok && reg_file_wr_addr == a1) ?
                      reg_file_wr_data : regs[a1[AW-1:0]];
    assign rd2_data = !rd2_ok ? '0 :
                      (BYPASS && wr_ok && reg_file_wr_addr == a2) ?
                      reg_file_wr_data : regs[a2[AW-1:0]];

    always_comb begin
        imm32 = {{20{instruction_in[31]}}, instruction_in[31:20]};
        unique case (1'b1)
            op == OP_STORE:
                imm32 = {{20{instruction_in[31]}}, instruction_in[31:25],
                         instruction_in[11:7]};
            op == OP_BRANCH:
                imm32 = {{19{instruction_in[31]}}, instruction_in[31],
                         instruction_in[7], instruction_in[30:25],
                         instruction_in[11:8], 1'b0};
            op == OP_JAL:
                imm32 = {{11{instruction_in[31]}}, instruction_in[31],
                         instruction_in[19:12], instruction_in[20],
                         instruction_in[30:21], 1'b0};
            op == OP_LUI || op == OP_AUIPC:
                imm32 = {instruction_in[31:12], 12'b0};
            default: ;
        endcase
    end

    always_comb begin
        dec = bubble();
        illegal = 1'b0;
        dec.pc = pc_in;
        dec.opcode = op;
        dec.func7 = f7;
        dec.func3 = f3;
        dec.rs1 = a1;
        dec.rs2 = a2;
        dec.rd = ad;
        dec.imm = XLEN'($signed(imm32));
        dec.op1 = rd1_data;
        dec.op2 = rd2_data;
        dec.rs1_used = !(op == OP_LUI || op == OP_AUIPC || op == OP_JAL);
        dec.rs2_used = op == OP_RTYPE || op == OP_STORE || op == OP_BRANCH;
        unique case (op)
            OP_RTYPE: begin
                dec.wb_reg_file = 1'b1;
                illegal = !(f7 == 7'h00 || f7 == 7'h20 || f7 == 7'h01);
            end
            OP_IMM: begin
                dec.alu_src = 1'b1;
                dec.wb_reg_file = 1'b1;
            end
            OP_LOAD: begin
                dec.alu_src = 1'b1;
                dec.wb_load = 1'b1;
                dec.wb_reg_file = 1'b1;
                dec.mem_load_type = f3;
                illegal = f3 inside {3'b011, 3'b110, 3'b111};
            end
            OP_STORE: begin
                dec.alu_src = 1'b1;
                dec.mem_write = 1'b1;
                dec.mem_store_type = f3[1:0];
                illegal = f3[2] || f3[1:0] == 2'b11;
            end
            OP_BRANCH: illegal = f3[2:1] == 2'b01;
            OP_JAL:    dec.wb_reg_file = 1'b1;
            OP_JALR: begin
                dec.alu_src = 1'b1;
                dec.wb_reg_file = 1'b1;
                illegal = f3 != 3'b000;
            end
            OP_LUI, OP_AUIPC: begin
                dec.alu_src = 1'b1;
                dec.wb_reg_file = 1'b1;
            end
            OP_SYSTEM, OP_FENCE: ;
            default: illegal = 1'b1;
        endcase
        m_enc = op == OP_RTYPE && f7 == 7'h01;
        dec.is_m_op = ENABLE_M && m_enc;
        // RV32E: only x0..x15 exist for any register actually touched.
        e_bad = NUM_REGS == 16 && ((dec.rs1_used && a1[4])
                || (dec.rs2_used && a2[4]) || (dec.wb_reg_file && ad[4]));
        dec.invalid_inst = illegal || (!ENABLE_M && m_enc) || e_bad;
        if (dec.invalid_inst) begin
            dec.wb_reg_file = 1'b0;
            dec.is_m_op = 1'b0;
        end
    end

    assign hazard = if_valid && valid_q && q.wb_load && q.rd != 5'd0
                    && ((q.rd == dec.rs1 && dec.rs1_used)
                    || (q.rd == dec.rs2 && dec.rs2_used));
    assign advance = !valid_q || ex_ready;
    assign if_ready = advance && !hazard && !id_flush && !rst;

    // A held instruction tracks WB so its operands never go stale.
    assign ref1 = wr_ok && reg_file_wr_addr == q.rs1 && q.rs1_used;
    assign ref2 = wr_ok && reg_file_wr_addr == q.rs2 && q.rs2_used;

    always_ff @(posedge clk) begin
        if (rst || id_flush) begin
            valid_q <= 1'b0;
            q <= bubble();
        end else if (advance && if_ready && if_valid) begin
            valid_q <= 1'b1;
            q <= dec;
        end else if (advance) begin
            valid_q <= 1'b0;
            q <= bubble();
        end else begin
            if (ref1) q.op1 <= reg_file_wr_data;
            if (ref2) q.op2 <= reg_file_wr_data;
        end
    end

    assign stall = hazard;
    assign id_valid = valid_q;
    assign id_pc = q.pc;
    assign op1 = q.op1;
    assign op2 = q.op2;
    assign immediate = q.imm;
    assign rs1 = q.rs1;
    assign rs2 = q.rs2;
    assign rd = q.rd;
    assign opcode = q.opcode;
    assign func7 = q.func7;
    assign func3 = q.func3;
    assign alu_src = q.alu_src;
    assign mem_write = q.mem_write;
    assign wb_load = q.wb_load;
    assign wb_reg_file = q.wb_reg_file;
    assign invalid_inst = q.invalid_inst;
    assign is_m_op = q.is_m_op;
    assign mem_load_type = q.mem_load_type;
    assign mem_store_type = q.mem_store_type;

endmodule
